// File: rtl/bcd_display_scheduler.sv
// rtl/bcd_display_scheduler.sv - shared binary-to-BCD converter sequencer with multiplexed 7-segment scan
// Converts one selected channel at a time and scans the captured 4-digit result with leading-zero blanking.
module bcd_display_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int SETTLE      = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*14-1:0]      ch_value,
  input  logic                      next_btn,
  output logic [13:0]               conv_bin,
  input  logic [15:0]               conv_bcd,
  output logic [$clog2(NUM_CH)-1:0] ch_idx,
  output logic                      busy,
  output logic                      overflow,
  output logic [3:0]                digit_an,
  output logic [3:0]                digit_bcd
);

  localparam int IW = $clog2(NUM_CH);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam logic [13:0] BCD_MAX = 14'd9999;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE} state_t;

  state_t        state;
  logic [13:0]   ch_arr [NUM_CH];
  logic [IW-1:0] ch_idx_new;
  logic [13:0]   sel_val;
  logic          sel_ovf;
  logic          ovf_tmp;
  logic          pending;
  logic [SW-1:0] scnt;
  logic [15:0]   disp;
  logic [RW-1:0] rcnt;
  logic [1:0]    didx;
  logic          refresh_wrap;
  logic          frame_start;
  logic          trigger;
  logic          blank;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_arr[g] = ch_value[14*g +: 14];
  end

  // The conversion launched on a next_btn edge must already see the advanced index.
  always_comb begin
    ch_idx_new = ch_idx;
    if (next_btn) begin
      ch_idx_new = (ch_idx == IW'(NUM_CH - 1)) ? '0 : ch_idx + 1'b1;
    end
  end

  assign sel_val      = ch_arr[ch_idx_new];
  assign sel_ovf      = (sel_val > BCD_MAX);
  assign refresh_wrap = (rcnt == RW'(REFRESH_DIV - 1));
  assign frame_start  = refresh_wrap && (didx == 2'd3);
  assign trigger      = pending | frame_start | next_btn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      conv_bin <= '0;
      ch_idx   <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      ovf_tmp  <= 1'b0;
      pending  <= 1'b1;
      scnt     <= '0;
      disp     <= '0;
    end else begin
      if (next_btn) begin
        ch_idx <= ch_idx_new;
      end
      case (state)
        S_IDLE: begin
          if (trigger) begin
            conv_bin <= sel_ovf ? BCD_MAX : sel_val;
            ovf_tmp  <= sel_ovf;
            busy     <= 1'b1;
            pending  <= 1'b0;
            if (SETTLE == 0) begin
              state <= S_CAPTURE;
            end else begin
              state <= S_SETTLE;
              scnt  <= SW'(SETTLE > 0 ? SETTLE - 1 : 0);
            end
          end
        end
        S_SETTLE: begin
          if (next_btn || frame_start) begin
            pending <= 1'b1;
          end
          if (scnt == '0) begin
            state <= S_CAPTURE;
          end else begin
            scnt <= scnt - 1'b1;
          end
        end
        S_CAPTURE: begin
          if (next_btn || frame_start) begin
            pending <= 1'b1;
          end
          disp     <= conv_bcd;
          overflow <= ovf_tmp;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A digit is dark when it and every more-significant digit are zero; units always show.
  always_comb begin
    case (didx)
      2'd1:    blank = (disp[15:4] == 12'd0);
      2'd2:    blank = (disp[15:8] == 8'd0);
      2'd3:    blank = (disp[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt      <= '0;
      didx      <= 2'd0;
      digit_an  <= 4'b1111;
      digit_bcd <= 4'd0;
    end else begin
      digit_bcd <= disp[{didx, 2'b00} +: 4];
      digit_an  <= blank ? 4'b1111 : ~(4'b0001 << didx);
      if (refresh_wrap) begin
        rcnt <= '0;
        didx <= didx + 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end

endmodule
